// File: rtl/pa_f_spsram_wrap_pkg.sv
// Shared FPGA RAM definitions: default wrapper geometry, wrapper FSM states and
// the helper that locates the sampled write-enable bit of each lane.
package pa_f_spsram_wrap_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_WRAP_SIZE  = 21;
  localparam int DEF_WRAP_NUM   = 2;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } spsram_state_e;

  // Only the lowest WEN bit of each lane is honoured.
  function automatic int lane_wen_bit(input int lane, input int wrap_size);
    return lane * wrap_size;
  endfunction

endpackage

// File: rtl/pa_f_spsram_wrap_fpga_ram.sv
// Single-port, write-first synchronous RAM lane used by the spsram wrappers.
module fpga_ram
  import pa_f_spsram_wrap_pkg::*;
#(
  parameter int DATA_W     = DEF_WRAP_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  WE,
  input  logic [DATA_W-1:0]     D,
  output logic [DATA_W-1:0]     Q
);

  logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge CLK) begin
    if (WE) begin
      mem[A] <= D;
      Q      <= D;
    end else begin
      Q <= mem[A];
    end
  end

endmodule

// File: rtl/pa_f_spsram_wrap.sv
// Parametrised single-port SRAM wrapper: WRAP_NUM lanes with per-lane write
// enables, post-reset zero-fill, optional output register and a zero Q until read.
module pa_f_spsram_wrap
  import pa_f_spsram_wrap_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WRAP_SIZE  = DEF_WRAP_SIZE,
  parameter int WRAP_NUM   = DEF_WRAP_NUM,
  parameter int DATA_WIDTH = WRAP_SIZE * WRAP_NUM,
  parameter int OUT_REG    = 0,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_BUSY
);

  spsram_state_e         state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic [DATA_WIDTH-1:0] ram_d;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [WRAP_NUM-1:0]   lane_we;
  logic                  rd_valid;
  logic                  acc;
  logic                  unused_wen;

  // Non-lane WEN bits are deliberately ignored.
  assign unused_wen = ^WEN;

  assign acc       = (state == ST_READY) && !CEN && !RST;
  assign ram_a     = (state == ST_INIT) ? init_cnt : (!CEN ? A : addr_hold);
  assign ram_d     = (state == ST_INIT) ? '0 : D;
  assign INIT_BUSY = (state == ST_INIT);

  for (genvar k = 0; k < WRAP_NUM; k++) begin : g_lane
    localparam int WB = lane_wen_bit(k, WRAP_SIZE);

    assign lane_we[k] = (state == ST_INIT) ? !RST : (acc && !GWEN && !WEN[WB]);

    fpga_ram #(
      .DATA_W    (WRAP_SIZE),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
      .CLK(CLK),
      .A  (ram_a),
      .WE (lane_we[k]),
      .D  (ram_d[k*WRAP_SIZE +: WRAP_SIZE]),
      .Q  (ram_q[k*WRAP_SIZE +: WRAP_SIZE])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= (INIT_EN != 0) ? ST_INIT : ST_READY;
      init_cnt <= '0;
      rd_valid <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          addr_hold <= init_cnt;
          init_cnt  <= init_cnt + ADDR_WIDTH'(1);
          if (init_cnt == '1) state <= ST_READY;
        end
        default: begin
          if (acc) begin
            addr_hold <= A;
            rd_valid  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Stage p1 -> p2: RAM output captured the cycle after an accepted access.
  if (OUT_REG != 0) begin : g_oreg
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] q_p2;

    always_ff @(posedge CLK) begin
      if (RST) begin
        vld_p1 <= 1'b0;
        q_p2   <= '0;
      end else begin
        vld_p1 <= acc;
        if (vld_p1) q_p2 <= ram_q;
      end
    end

    assign Q = rd_valid ? q_p2 : '0;
  end else begin : g_noreg
    assign Q = rd_valid ? ram_q : '0;
  end

endmodule

// File: tb/tb_pa_f_spsram_wrap.sv
// Scoreboard bench: default-geometry wrapper plus a 4x8-bit, registered-output,
// no-init wrapper, both checked every cycle against a behavioural memory model.
module tb_pa_f_spsram_wrap;

  localparam int AW0 = 7, WS0 = 21, WN0 = 2, DW0 = 42;
  localparam int AW1 = 4, WS1 = 8,  WN1 = 4, DW1 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [AW0-1:0] a0;
  logic           cen0, gwen0, busy0;
  logic [DW0-1:0] wen0, d0, q0;
  logic [AW1-1:0] a1;
  logic           cen1, gwen1, busy1;
  logic [DW1-1:0] wen1, d1, q1;

  pa_f_spsram_wrap u_dut0 (
    .CLK(clk), .RST(rst), .A(a0), .CEN(cen0), .GWEN(gwen0), .WEN(wen0),
    .D(d0), .Q(q0), .INIT_BUSY(busy0)
  );

  pa_f_spsram_wrap #(
    .ADDR_WIDTH(AW1), .WRAP_SIZE(WS1), .WRAP_NUM(WN1), .OUT_REG(1), .INIT_EN(0)
  ) u_dut1 (
    .CLK(clk), .RST(rst), .A(a1), .CEN(cen1), .GWEN(gwen1), .WEN(wen1),
    .D(d1), .Q(q1), .INIT_BUSY(busy1)
  );

  typedef struct {
    int          due;
    int          kind;
    logic [63:0] exp;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    k1 = 0;
  string names[4] = '{"q0", "busy0", "q1", "busy1"};

  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: plain arrays describing memory contents and visible data.
  logic [DW0-1:0] m0 [128];
  int             init_left0 = 0;
  bit             val0 = 1'b0;
  int             last0 = 0;
  logic [DW1-1:0] m1 [16];
  bit             pend1 = 1'b0;
  logic [DW1-1:0] snap1 = '0;
  logic [DW1-1:0] qreg1 = '0;

  function automatic void push(input int kind, input logic [63:0] exp);
    exp_t e;
    e.due  = cyc + 1;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endfunction

  task automatic model_and_push();
    if (rst) begin
      init_left0 = 128;
      val0       = 1'b0;
      for (int i = 0; i < 128; i++) m0[i] = '0;
    end else if (init_left0 > 0) begin
      init_left0--;
    end else if (!cen0) begin
      for (int k = 0; k < WN0; k++)
        if (!gwen0 && !wen0[k*WS0]) m0[a0][k*WS0 +: WS0] = d0[k*WS0 +: WS0];
      last0 = int'(a0);
      val0  = 1'b1;
    end
    push(0, val0 ? 64'(m0[last0]) : 64'd0);
    push(1, 64'(init_left0 > 0));

    if (rst) begin
      pend1 = 1'b0;
      qreg1 = '0;
    end else begin
      if (pend1) qreg1 = snap1;
      pend1 = 1'b0;
      if (!cen1) begin
        for (int k = 0; k < WN1; k++)
          if (!gwen1 && !wen1[k*WS1]) m1[a1][k*WS1 +: WS1] = d1[k*WS1 +: WS1];
        snap1 = m1[a1];
        pend1 = 1'b1;
      end
    end
    push(2, 64'(qreg1));
    push(3, 64'd0);
  endtask

  task automatic drive1();
    cen1 = 1'b1; gwen1 = 1'b1; wen1 = '1; a1 = '0; d1 = '0;
    if (k1 == 1) begin
      cen1 = 1'b0; gwen1 = 1'b0; wen1 = '0; a1 = 4'd15; d1 = 32'hDEADBEEF;
    end else if (k1 == 2) begin
      cen1 = 1'b0; a1 = 4'd15;
    end else if (k1 >= 4 && k1 < 20) begin
      cen1 = 1'b0; gwen1 = 1'b0; wen1 = '0; a1 = AW1'(k1 - 4); d1 = $urandom;
    end else if (k1 >= 20) begin
      cen1  = ($urandom_range(0, 3) == 0);
      gwen1 = 1'($urandom_range(0, 1));
      wen1  = $urandom;
      a1    = AW1'($urandom_range(0, 15));
      d1    = $urandom;
    end
    if (!rst) k1++;
  endtask

  task automatic step();
    drive1();
    model_and_push();
    @(posedge clk);
    #2;
  endtask

  task automatic idle0();
    cen0 = 1'b1; gwen0 = 1'b1; wen0 = '1; a0 = '0; d0 = '0;
  endtask

  task automatic acc0(input logic [AW0-1:0] a, input logic [DW0-1:0] d,
                      input logic gw, input logic [DW0-1:0] w);
    cen0 = 1'b0; gwen0 = gw; wen0 = w; a0 = a; d0 = d;
  endtask

  task automatic wait_init();
    while (init_left0 > 0) begin
      idle0();
      step();
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t        e;
    logic [63:0] act;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = 64'(q0);
        1:       act = 64'(busy0);
        2:       act = 64'(q1);
        default: act = 64'(busy1);
      endcase
      checks++;
      if (e.due != cyc || act !== e.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d due=%0d got=%h want=%h", names[e.kind], cyc, e.due, act, e.exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [DW0-1:0] lane_mask;
    int             i;

    rst = 1'b1;
    idle0();
    step();
    step();
    rst = 1'b0;

    // Accesses during zero-fill must be ignored.
    i = 0;
    while (init_left0 > 0) begin
      if (i < 3) acc0(7'd3, 42'h3FF, 1'b0, '0);
      else idle0();
      step();
      i++;
    end

    acc0(7'd0,   '0, 1'b1, '1); step();
    acc0(7'd64,  '0, 1'b1, '1); step();
    acc0(7'd127, '0, 1'b1, '1); step();

    acc0(7'd5, 42'h2AA_AAAA_AAAA, 1'b0, '0); step();
    acc0(7'd5, '0, 1'b1, '1); step();
    idle0();
    repeat (4) step();

    lane_mask = '0;
    lane_mask[21] = 1'b1;
    acc0(7'd9, '1, 1'b0, '0); step();
    acc0(7'd9, '0, 1'b0, lane_mask); step();
    acc0(7'd9, '0, 1'b1, '1); step();
    acc0(7'd3, '0, 1'b1, '1); step();

    acc0(7'd10, DW0'({$urandom, $urandom}), 1'b0, '0); step();
    rst = 1'b1; idle0(); step();
    rst = 1'b0;
    wait_init();
    acc0(7'd10, '0, 1'b1, '1); step();

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 2) == 0) begin
        idle0();
      end else begin
        acc0($urandom_range(0, 1) ? AW0'($urandom_range(0, 15)) : AW0'($urandom_range(0, 127)),
             DW0'({$urandom, $urandom}), 1'($urandom_range(0, 1)), DW0'({$urandom, $urandom}));
      end
      step();
    end
    rst = 1'b0;
    idle0();
    step();
    step();

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pa_f_spsram_wrap.md
# pa_f_spsram_wrap

Parametrised single-port FPGA SRAM wrapper: the next generation of the fixed-geometry spsram wrappers. It splits a `WRAP_NUM*WRAP_SIZE`-bit word across `WRAP_NUM` `fpga_ram` lanes, each with its own write enable. It adds three things the fixed wrappers lack: hardware zero-initialisation after reset, an optional output register, and a defined `Q` before the first read. It drops in wherever the cache, BHT and tag arrays instantiate a generated spsram on FPGA builds.

## Interface
Parameters:
- `ADDR_WIDTH`, 7, address bits; depth is `2**ADDR_WIDTH`.
- `WRAP_SIZE`, 21, bits per lane.
- `WRAP_NUM`, 2, number of lanes (1..8).
- `DATA_WIDTH`, `WRAP_SIZE*WRAP_NUM`, derived; must not be overridden.
- `OUT_REG`, 0, 1 adds a `Q` output register (read latency 2).
- `INIT_EN`, 1, 1 zero-fills the array after reset.

Ports:
- `CLK`  in  1  clock; all logic on posedge.
- `RST`  in  1  synchronous, active-high reset.
- `A`  in  ADDR_WIDTH  address.
- `CEN`  in  1  chip enable, active low.
- `GWEN`  in  1  global write enable, active low.
- `WEN`  in  DATA_WIDTH  bit write enables, active low; only bit `k*WRAP_SIZE` is sampled for lane k.
- `D`  in  DATA_WIDTH  write data.
- `Q`  out  DATA_WIDTH  read data.
- `INIT_BUSY`  out  1  high while the zero-fill is in progress; accesses are ignored.

## Operation
- FSM states: `INIT` and `READY`.
  - `RST` = 1 → `INIT`, with the init counter at 0 and `rd_valid` at 0.
  - If `INIT_EN` = 0, reset goes straight to `READY`.
- `INIT` state:
  - Each cycle, all lanes write 0 at the counter address, then the counter increments.
  - When the counter equals `2**ADDR_WIDTH-1`, that write completes and the next state is `READY`. Counter wrap-around never occurs.
  - External `CEN`/`GWEN`/`WEN`/`A`/`D` are ignored. No error is flagged.
- `READY` state:
  - Accepted access is `CEN` = 0.
  - Lane k write enable = `!CEN && !GWEN && !WEN[k*WRAP_SIZE]`.
  - Lane k data = `D[k*WRAP_SIZE +: WRAP_SIZE]`.
  - A write with no lane enabled behaves as a read.
- Address holding:
  - The holding register loads `A` on each accepted access. In `INIT` it tracks the init counter.
  - The RAM address is `A` when `CEN` = 0, otherwise the holding register. `Q` is therefore stable across idle (`CEN` = 1) cycles.
- `fpga_ram` is write-first: after a write, `Q` shows the new data in written lanes and the old data in unwritten lanes.
- `rd_valid`: reset 0; set on the first accepted `READY` access; never cleared except by `RST`.
- `Q` is 0 while `rd_valid` = 0.
- `OUT_REG` = 1:
  - The `Q` register loads the RAM output in the cycle after an accepted access and holds otherwise.
  - Reset value is 0.
- `RST` mid-operation (in `INIT` or `READY`): init restarts at address 0 and `Q` returns to 0. Memory contents are then re-zeroed.

## Timing
- Reset values: `INIT_BUSY` = `INIT_EN`; `Q` = 0.
- `INIT_BUSY` stays high for exactly `2**ADDR_WIDTH` cycles after the cycle `RST` deasserts, then falls.
- The first access is accepted in the first cycle with `INIT_BUSY` = 0.
- Read latency:
  - `OUT_REG` = 0: access at edge n, `Q` valid after edge n.
  - `OUT_REG` = 1: `Q` valid after edge n+1.
- Back-to-back accesses sustain one per cycle; there is no stall.
- Simultaneous `RST` and access: `RST` wins and the access is dropped.

## Structure
- Geometry defaults and the lane-enable bit index function live in the shared FPGA RAM include, alongside `fpga_ram`.
- One sub-module type, `fpga_ram #(WRAP_SIZE, ADDR_WIDTH)`, instantiated `WRAP_NUM` times in a generate loop.
- The FSM, init counter, address holding, `rd_valid` and the output register live in this module.

## Test plan
- Reset with defaults → `INIT_BUSY` = 1 for 128 cycles, then 0; read addresses 0, 64 and 127 → `Q` = 0.
- Write `D` = 42'h2AA_AAAA_AAAA to address 5 with all lanes enabled, then read address 5 → `Q` = 42'h2AA_AAAA_AAAA one cycle later. Hold `CEN` = 1 for 4 cycles → `Q` unchanged.
- Lane mask:
  - Write all-ones to address 9.
  - Write 0 with `WEN[0]` = 0 and `WEN[21]` = 1.
  - Read address 9 → `Q[20:0]` = 0, `Q[41:21]` = 21'h1FFFFF.
- Accesses driven during `INIT` (write 42'h3FF to address 3) → ignored; after init, address 3 reads 0.
- `RST` pulsed after writing address 10 in `READY` → `Q` = 0 and `INIT_BUSY` re-asserts for 128 cycles; address 10 then reads 0.
- `WRAP_NUM` = 4, `WRAP_SIZE` = 8, `ADDR_WIDTH` = 4, `OUT_REG` = 1, `INIT_EN` = 0:
  - Write 32'hDEADBEEF to address 15, then read address 15 → `Q` = 32'hDEADBEEF two edges after the read.
  - `Q` = 0 before the first access.
